// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Consumes UART RX bytes: SYNC_BYTE, 16-bit word count (LE), then count
// little-endian 32-bit words, each written to BASE_ADDR + 4*k.
// Holds the core in reset (core_hold_n low) while loading or after an error.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte; the byte sum of all data plus the checksum must be 0 mod 256.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 4096,
   parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        core_hold_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_t;

   // State entered once the header/data part of a load is complete.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_ST = S_CSUM;
`else
   localparam state_t END_ST = S_FIN;
`endif

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  lane_q, lane_d;
   logic [23:0] sh_q, sh_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif

   // Full word count as it becomes known on the second header byte.
   logic [15:0] n_rx;
   assign n_rx = {rx_data, len_q[7:0]};

   // Next-state and datapath update for the load sequence.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      lane_d    = lane_q;
      sh_d      = sh_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
      error_d   = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d = S_LEN0;
               done_d  = 1'b0;
               error_d = 1'b0;
               cnt_d   = 16'd0;
               lane_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = 8'd0;
`endif
            end
         end
         S_LEN0: begin
            if (rx_valid) begin
               len_d   = {8'h00, rx_data};
               state_d = S_LEN1;
            end
         end
         S_LEN1: begin
            if (rx_valid) begin
               len_d = n_rx;
               if (n_rx == 16'd0) begin
                  state_d = END_ST;
               end else if (32'(n_rx) > MAX_WORDS) begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d = sum_q + rx_data;
`endif
               if (lane_q == 2'd3) begin
                  // Fourth byte completes the word: issue the write next cycle.
                  wr_en_d   = 1'b1;
                  wr_data_d = {rx_data, sh_q};
                  wr_addr_d = BASE_ADDR + {14'd0, cnt_q, 2'b00};
                  cnt_d     = cnt_q + 16'd1;
                  lane_d    = 2'd0;
                  if (cnt_q == (len_q - 16'd1)) begin
                     state_d = END_ST;
                  end
               end else begin
                  sh_d   = {rx_data, sh_q[23:8]};
                  lane_d = lane_q + 2'd1;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               if (8'(sum_q + rx_data) == 8'h00) begin
                  state_d = S_FIN;
               end else begin
                  error_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
`endif
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; every output returns to its reset value
   // as soon as reset_n falls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         len_q     <= 16'd0;
         cnt_q     <= 16'd0;
         lane_q    <= 2'd0;
         sh_q      <= 24'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= 32'd0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         lane_q    <= lane_d;
         sh_q      <= sh_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign error       = error_q;
   assign core_hold_n = !busy && !error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte streams are generated together with their
// expected writes, final flags and event cycles, then driven with random gaps.
module tb_imem_loader;
   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   localparam int          MAXW = 4096;
   localparam logic [7:0]  SYNC = 8'h55;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        wr_en, busy, done, error, core_hold_n;
   logic [31:0] wr_addr, wr_data;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
      .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .done(done), .error(error), .core_hold_n(core_hold_n));

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: log every write and the cycles where busy/done rise.
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];
   int          busy_rise = -1;
   int          done_rise = -1;
   logic        busy_prev = 1'b0;
   logic        done_prev = 1'b0;
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         got_addr.push_back(wr_addr);
         got_data.push_back(wr_data);
         got_cyc.push_back(cyc);
      end
      if (busy && !busy_prev) busy_rise = cyc;
      if (done && !done_prev) done_rise = cyc;
      busy_prev = busy;
      done_prev = done;
   end

   // Stream under construction and its expectations.
   logic [7:0]  stream[$];
   logic [7:0]  pre[$];
   logic [7:0]  payload[$];
   int          drv_cyc[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_idx[$];
   int          sync_idx, last_idx, rbase;
   logic        exp_done, exp_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] junk();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      return b;
   endfunction

   task automatic new_stream();
      stream.delete(); pre.delete(); payload.delete(); drv_cyc.delete();
      exp_addr.delete(); exp_data.delete(); exp_idx.delete();
   endtask

   // Append one load (junk prefix, sync, count, words[, checksum]) and
   // record what the loader must do with it.
   task automatic add_load(input int n, input logic corrupt);
      logic [7:0]  b;
      logic [7:0]  sum;
      logic [31:0] w;
      logic [15:0] n16;
      n16 = 16'(n);
      sum = 8'h00;
      foreach (pre[i]) stream.push_back(pre[i]);
      sync_idx = stream.size();
      stream.push_back(SYNC);
      stream.push_back(n16[7:0]);
      stream.push_back(n16[15:8]);
      exp_err  = 1'b0;
      exp_done = 1'b0;
      if (n > MAXW) begin
         exp_err = 1'b1;
      end else begin
         for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int l = 0; l < 4; l++) begin
               if (payload.size() > 0) b = payload.pop_front();
               else if ($urandom_range(7, 0) == 0) b = SYNC;
               else b = 8'($urandom);
               w[8*l +: 8] = b;
               sum = sum + b;
               stream.push_back(b);
            end
            exp_addr.push_back(BASE + 32'(4 * k));
            exp_data.push_back(w);
            exp_idx.push_back(stream.size() - 1);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         stream.push_back((8'h00 - sum) ^ {7'd0, corrupt});
         exp_err = corrupt;
`else
         if (corrupt && (sum == 8'h00)) exp_err = 1'b0;
`endif
         exp_done = !exp_err;
      end
      last_idx = stream.size() - 1;
   endtask

   task automatic drive(input int gapmax, input int limit);
      int g;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         rx_valid = 1'b1;
         rx_data  = stream[i];
         drv_cyc.push_back(cyc);
         g = $urandom_range(gapmax, 0);
         repeat (g) begin
            @(negedge clock);
            rx_valid = 1'b0;
         end
      end
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic run(input int gapmax);
      int nw;
      rbase = got_addr.size();
      drive(gapmax, stream.size());
      repeat (4) @(negedge clock);
      nw = got_addr.size() - rbase;
      chk("nwr", nw, exp_addr.size());
      for (int j = 0; j < exp_addr.size(); j++) begin
         chk("waddr", got_addr[rbase + j], exp_addr[j]);
         chk("wdata", got_data[rbase + j], exp_data[j]);
         chk("wcyc", got_cyc[rbase + j], drv_cyc[exp_idx[j]] + 1);
      end
      chk("busy_rise", busy_rise, drv_cyc[sync_idx] + 1);
      if (exp_done) chk("done_rise", done_rise, drv_cyc[last_idx] + 2);
      chk("done", 32'(done), 32'(exp_done));
      chk("error", 32'(error), 32'(exp_err));
      chk("busy", 32'(busy), 32'd0);
      chk("hold_n", 32'(core_hold_n), 32'(!exp_err));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_addr"}, wr_addr, BASE);
      chk({tag, "_wr_data"}, wr_data, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_hold_n"}, 32'(core_hold_n), 32'd1);
   endtask

   initial begin
      int jn;
      repeat (2) @(negedge clock);
      chk_reset_vals("rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Two-word program from the reference stream.
      new_stream();
      payload = '{8'h13, 8'h05, 8'h10, 8'h04, 8'hEF, 8'h00, 8'h00, 8'h02};
      add_load(2, 1'b0);
      run(2);
      chk("tp1_a0", got_addr[rbase], BASE);
      chk("tp1_d0", got_data[rbase], 32'h04100513);
      chk("tp1_d1", got_data[rbase + 1], 32'h020000EF);

      // Junk before sync, back-to-back bytes.
      new_stream();
      pre = '{8'h00, 8'hAA};
      payload = '{8'h6F, 8'h00, 8'h00, 8'h00};
      add_load(1, 1'b0);
      run(0);
      chk("tp2_d0", got_data[rbase], 32'h0000006F);

      // Oversize count, then a good load that clears error.
      new_stream();
      add_load(MAXW + 1, 1'b0);
      run(1);
      new_stream();
      add_load(3, 1'b0);
      run(1);

      // Zero-word load.
      new_stream();
      add_load(0, 1'b0);
      run(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      new_stream();
      payload = '{8'h01, 8'h02, 8'h03, 8'h04};
      add_load(1, 1'b0);
      chk("csum_byte", 32'(stream[last_idx]), 32'h000000F6);
      run(1);
      new_stream();
      payload = '{8'h01, 8'h02, 8'h03, 8'h04};
      add_load(1, 1'b1);
      run(1);
`endif

      // Reset after two of three words.
      new_stream();
      add_load(3, 1'b0);
      rbase = got_addr.size();
      drive(1, 3 + 8 + 2);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (6) @(negedge clock);
      chk("midrst_nwr", got_addr.size() - rbase, 2);
      chk("midrst_a1", got_addr[rbase + 1], exp_addr[1]);
      chk("midrst_d1", got_data[rbase + 1], exp_data[1]);
      new_stream();
      add_load(2, 1'b0);
      run(1);

      // Randomized loads.
      for (int t = 0; t < 10; t++) begin
         new_stream();
         jn = $urandom_range(3, 0);
         repeat (jn) pre.push_back(junk());
         add_load($urandom_range(6, 1), 1'($urandom_range(1, 0)));
         run($urandom_range(3, 0));
      end

      // Largest accepted count, continuous stream.
      new_stream();
      add_load(MAXW, 1'b0);
      run(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. It consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and drives the instruction memory write port. It holds the core in reset while a program is loading. It is the write-side counterpart of the fetch-side instruction memory read path and sits between the UART RX block and the instruction memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word aligned.
- `MAX_WORDS`, default 4096: largest accepted word count.
- `SYNC_BYTE`, default 8'h55: byte that starts a load.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle. Back-to-back strobes are legal.
- `wr_en`  out  1  one-cycle instruction memory write strobe.
- `wr_addr`  out  32  byte address of the write; bits [1:0] are always 0. The memory indexes by `wr_addr >> 2`.
- `wr_data`  out  32  word to write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky; set when the last word has been written successfully.
- `error`  out  1  sticky load failure.
- `core_hold_n`  out  1  active-low core reset request; low while loading or after an error.

## Operation
- States: IDLE, LEN0, LEN1, DATA, CSUM (only with the configuration macro), FIN.
- **IDLE**
  - A byte equal to `SYNC_BYTE` moves to LEN0 and clears `done`, `error`, the word counter, the byte lane and the checksum.
  - Any other byte is ignored.
- **LEN0 / LEN1**
  - Collect a 16-bit word count N, low byte first.
  - N == 0 goes to FIN, or to CSUM when the macro is defined.
  - N > `MAX_WORDS` sets `error` and returns to IDLE; no write is issued.
- **DATA**
  - Bytes fill lanes 0..3 of a shift register, little-endian: the first byte is `wr_data[7:0]`.
  - When the 4th byte is accepted, `wr_en` pulses on the next cycle with `wr_addr = BASE_ADDR + 4*k`, where k is the 0-based word index.
  - The word counter increments with the pulse.
  - After word N-1 the state moves to FIN, or to CSUM when the macro is defined.
- **FIN**
  - Sets `done`, releases `core_hold_n` and returns to IDLE in the same transition.
- `busy` = (state != IDLE).
- `core_hold_n` = !busy && !error.
- A `SYNC_BYTE` value received outside IDLE is treated as data and does not restart the load.
- Address arithmetic is 32-bit and wraps modulo 2^32; no range check beyond `MAX_WORDS`.

## Timing
- Reset values: state IDLE, `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `core_hold_n`=1.
- Latency:
  - `wr_en` is asserted exactly one cycle after the `rx_valid` that carried byte 3 of a word.
  - `wr_addr` and `wr_data` are registered and valid only while `wr_en`=1.
- Throughput: with `rx_valid` held high continuously, one write every 4 cycles; no back-pressure exists.
- `busy` rises, and `core_hold_n` falls, the cycle after the sync byte.
- `done` rises the cycle after the final `wr_en`. Without the macro, `busy` falls in that same cycle.
- Reset mid-load returns all outputs to their reset values immediately. The partially written memory is left as is.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The byte after the last data word is a checksum C.
  - The load is valid when (sum of all data bytes + C) mod 256 == 0. Header bytes are not summed.
  - On a match, CSUM goes to FIN.
  - On a mismatch, CSUM sets `error`, leaves `done`=0 and returns to IDLE.
  - `core_hold_n` stays low until the next sync byte or reset.
- `IMEM_LOADER_CHECKSUM_EN` undefined:
  - No CSUM state and no checksum register.
  - `error` is set only by an oversize count.

## Test plan
- Reset, then bytes 55 02 00 13 05 10 04 EF 00 00 02 → `wr_en` pulses twice:
  - (0x0, 0x04100513)
  - (0x4, 0x020000EF)
  - Then `done`=1, `busy`=0, `core_hold_n`=1.
- Bytes 00 AA 55 01 00 6F 00 00 00 sent back-to-back on consecutive cycles → the first two bytes are ignored; one write (0x0, 0x0000006F) lands 1 cycle after the 0x00 that is byte 3 of the word.
- Count 0x1001 with `MAX_WORDS`=4096 → `error`=1, no `wr_en`, `core_hold_n`=0; a later valid load clears `error`.
- Count 0 → no writes, `done`=1.
- `reset_n` low after 2 of 3 words → outputs return to reset values asynchronously; no third write; a new load starts at `BASE_ADDR`.
- Macro on: 55 01 00 01 02 03 04 F6 → `done`=1. The same stream with F7 → `error`=1, `done`=0.
